fifo_sync_param: RTL



---
 rtl/fifo_sync_param_pkg.sv | 35 +++
 rtl/fifo_sync_param_ram.sv | 40 ++++
 rtl/fifo_sync_param.sv | 117 +++++++++++
 3 files changed

// File: rtl/fifo_sync_param_pkg.sv
// Shared FIFO helpers: width derivation and the status-flag bundle.
package fifo_sync_param_pkg;

  // Ceiling log2 usable in constant expressions; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Pointer width for a power-of-two depth; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (clog2(depth) > 0) ? clog2(depth) : 1;
  endfunction

  // Occupancy counter needs one extra bit to represent the full state.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

  // Occupancy-derived status flags.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

endpackage

// File: rtl/fifo_sync_param_ram.sv
// Simple dual-port RAM: synchronous write port, registered read port with
// read enable. Read register has a synchronous reset so the FIFO output
// comes up as zero.
module fifo_sdp_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port; storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; holds its value when not enabled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO: pointers, occupancy counter, flag decode
// and overflow/underflow pulses around a simple dual-port RAM.
module fifo_sync_param
  import fifo_sync_param_pkg::*;
#(
  parameter  int unsigned DATA_W   = 8,
  parameter  int unsigned DEPTH    = 64,
  parameter  int unsigned AF_LEVEL = DEPTH - 4,
  parameter  int unsigned AE_LEVEL = 4,
  localparam int unsigned PTR_W    = ptr_width(DEPTH),
  localparam int unsigned CNT_W    = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] buf_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] buf_out,
  output logic              rd_vld,
  output logic              buf_full,
  output logic              buf_empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  output logic [CNT_W-1:0]  fifo_counter
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_vld_q, rd_vld_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  fifo_flags_t      flags;
  logic             wr_acc, rd_acc;

  // Flag decode from the registered counter only, so flags are glitch-free.
  always_comb begin
    flags              = '0;
    flags.full         = (cnt_q == CNT_W'(DEPTH));
    flags.empty        = (cnt_q == '0);
    flags.almost_full  = (cnt_q >= CNT_W'(AF_LEVEL));
    flags.almost_empty = (cnt_q <= CNT_W'(AE_LEVEL));
  end

  // Accept decisions use pre-edge flags; a cycle with reset high accepts nothing.
  always_comb begin
    wr_acc = wr_en & ~flags.full  & ~rst;
    rd_acc = rd_en & ~flags.empty & ~rst;
  end

  // Next-state for pointers, counter, read-valid and error pulses.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    rd_vld_d = rd_acc;
    ovf_d    = wr_en & flags.full;
    unf_d    = rd_en & flags.empty;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rd_vld_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rd_vld_q <= rd_vld_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (buf_in),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (buf_out)
  );

  assign rd_vld       = rd_vld_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign fifo_counter = cnt_q;
  assign buf_full     = flags.full;
  assign buf_empty    = flags.empty;
  assign almost_full  = flags.almost_full;
  assign almost_empty = flags.almost_empty;

endmodule
